// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - HD44780-style LCD bus-timing sequencer
//
// Turns one firmware register write into a timed RS/DATA setup, EN pulse,
// hold and execution wait, with a one-deep pending slot.
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_lcd_word  LCD register: [31] ON, [10] REQ toggle, [9] RS, [8] RW, [7:0] DATA
//   o_lcd_on    registered copy of the ON bit
//   o_lcd_en    EN strobe
//   o_lcd_rs    register select
//   o_lcd_rw    read/write select, always write
//   o_lcd_data  data bus
//   o_busy      transaction in progress or pending
//   o_overrun   sticky, a request was dropped
module lcd_cmd_sequencer #(
   parameter int T_SETUP = 3,
   parameter int T_PW    = 12,
   parameter int T_HOLD  = 2,
   parameter int T_EXEC  = 2500,
   parameter int T_LONG  = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_lcd_word,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data,
   output logic        o_busy,
   output logic        o_overrun
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T_MAX = max2(max2(max2(T_LONG, T_EXEC), max2(T_PW, T_SETUP)), T_HOLD);
   localparam int CW    = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] C_PW    = CW'(T_PW - 1);
   localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
   localparam logic [CW-1:0] C_LONG  = CW'(T_LONG - 1);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            req_last;
   logic            pend_valid;
   logic            pend_rs;
   logic [7:0]      pend_data;

   logic            req;
   logic            cnt_zero;
   logic            chain;
   logic            launch;
   logic            idle_next;
   logic            pend_next;
   logic            is_long;
   logic            unused;

   assign o_lcd_rw = 1'b0;
   assign unused   = ^{i_lcd_word[30:11], i_lcd_word[8]};

   always_comb begin
      req      = i_lcd_word[10] ^ req_last;
      cnt_zero = (cnt == '0);
      // A pending request is launched either straight out of WAIT or from
      // IDLE when it was captured on the very edge WAIT ended.
      chain    = pend_valid && ((state == IDLE) || ((state == WAIT) && cnt_zero));
      launch   = chain || ((state == IDLE) && req);
      idle_next = ((state == IDLE) && !launch) ||
                  ((state == WAIT) && cnt_zero && !chain);
      // Launching from pending frees the slot, so a same-cycle request refills it.
      pend_next = chain ? req : (pend_valid || (req && (state != IDLE)));
      is_long  = !o_lcd_rs && ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         req_last   <= 1'b0;
         pend_valid <= 1'b0;
         pend_rs    <= 1'b0;
         pend_data  <= 8'h00;
         o_lcd_on   <= 1'b0;
         o_lcd_en   <= 1'b0;
         o_lcd_rs   <= 1'b0;
         o_lcd_data <= 8'h00;
         o_busy     <= 1'b0;
         o_overrun  <= 1'b0;
      end else begin
         o_lcd_on <= i_lcd_word[31];
         o_busy   <= !idle_next || pend_next;
         if (req)
            req_last <= i_lcd_word[10];

         // Pending slot: never overwritten while full; a full slot drops the request.
         if (chain) begin
            pend_valid <= req;
            if (req) begin
               pend_rs   <= i_lcd_word[9];
               pend_data <= i_lcd_word[7:0];
            end
         end else if (req && (state != IDLE)) begin
            if (pend_valid) begin
               o_overrun <= 1'b1;
            end else begin
               pend_valid <= 1'b1;
               pend_rs    <= i_lcd_word[9];
               pend_data  <= i_lcd_word[7:0];
            end
         end

         case (state)
            IDLE: ;
            SETUP:
               if (cnt_zero) begin
                  o_lcd_en <= 1'b1;
                  cnt      <= C_PW;
                  state    <= PULSE;
               end else cnt <= cnt - CW'(1);
            PULSE:
               if (cnt_zero) begin
                  o_lcd_en <= 1'b0;
                  cnt      <= C_HOLD;
                  state    <= HOLD;
               end else cnt <= cnt - CW'(1);
            HOLD:
               if (cnt_zero) begin
                  cnt   <= is_long ? C_LONG : C_EXEC;
                  state <= WAIT;
               end else cnt <= cnt - CW'(1);
            WAIT:
               if (cnt_zero) state <= IDLE;
               else          cnt   <= cnt - CW'(1);
            default: state <= IDLE;
         endcase

         // The bus only changes here, at the start of SETUP.
         if (launch) begin
            state      <= SETUP;
            cnt        <= C_SETUP;
            o_lcd_rs   <= chain ? pend_rs   : i_lcd_word[9];
            o_lcd_data <= chain ? pend_data : i_lcd_word[7:0];
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - self-checking bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;
   localparam int S = 2, PW = 3, H = 1, TE = 5, TL = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] word = '0;
   logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, overrun;
   logic [7:0]  lcd_data;

   lcd_cmd_sequencer #(.T_SETUP(S), .T_PW(PW), .T_HOLD(H), .T_EXEC(TE), .T_LONG(TL)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_lcd_word(word),
      .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
      .o_lcd_data(lcd_data), .o_busy(busy), .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int edge_n = 0;
   bit tb_req = 1'b0;
   bit exp_on = 1'b0;
   int ovr_at = -1;
   int en_rises = 0;
   bit en_prev = 1'b0;
   int busy_cnt;

   // Transaction-level schedule: request edge, start edge, end edge, bus values.
   int         tr_req[$];
   int         tr_start[$];
   int         tr_end[$];
   bit         tr_rs[$];
   logic [7:0] tr_data[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
      end
   endtask

   function automatic void model_req(input int k, input bit rs, input logic [7:0] d);
      int n, s, w;
      n = tr_start.size();
      if (n > 0 && tr_start[n-1] > k) begin
         if (ovr_at < 0) ovr_at = k;
         return;
      end
      if (n == 0 || k > tr_end[n-1]) s = k;
      else if (k == tr_end[n-1])     s = k + 1;
      else                           s = tr_end[n-1];
      w = (!rs && (d == 8'h01 || d == 8'h02)) ? TL : TE;
      tr_req.push_back(k);
      tr_start.push_back(s);
      tr_end.push_back(s + S + PW + H + w);
      tr_rs.push_back(rs);
      tr_data.push_back(d);
   endfunction

   task automatic model_clear();
      tr_req.delete(); tr_start.delete(); tr_end.delete(); tr_rs.delete(); tr_data.delete();
      ovr_at = -1; edge_n = 0; tb_req = 1'b0; exp_on = 1'b0; en_prev = 1'b0;
   endtask

   task automatic step();
      bit e_en, e_busy, e_rs;
      logic [7:0] e_data;
      @(posedge clk);
      edge_n++;
      exp_on = word[31];
      if (word[10] != tb_req) begin
         tb_req = word[10];
         model_req(edge_n, word[9], word[7:0]);
      end
      @(negedge clk);
      e_en = 1'b0; e_busy = 1'b0; e_rs = 1'b0; e_data = 8'h00;
      for (int i = 0; i < tr_start.size(); i++) begin
         if (tr_req[i] <= edge_n && edge_n < tr_end[i]) e_busy = 1'b1;
         if (tr_start[i] + S <= edge_n && edge_n < tr_start[i] + S + PW) e_en = 1'b1;
         if (tr_start[i] <= edge_n) begin
            e_rs = tr_rs[i];
            e_data = tr_data[i];
         end
      end
      check_eq("en", 32'(lcd_en), 32'(e_en));
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("rs", 32'(lcd_rs), 32'(e_rs));
      check_eq("data", 32'(lcd_data), 32'(e_data));
      check_eq("overrun", 32'(overrun), 32'(ovr_at >= 0 && ovr_at <= edge_n));
      check_eq("on", 32'(lcd_on), 32'(exp_on));
      check_eq("rw", 32'(lcd_rw), 32'd0);
      if (lcd_en && !en_prev) en_rises++;
      en_prev = lcd_en;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic toggle(input bit rs, input logic [7:0] d);
      word[10] = ~word[10];
      word[9] = rs;
      word[7:0] = d;
   endtask

   initial begin
      int r;
      logic [7:0] d;
      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_en", 32'(lcd_en), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_data", 32'(lcd_data), 0);
      check_eq("rst_ovr", 32'(overrun), 0);
      model_clear();
      rst_n = 1'b1;

      // Single data write: busy falls at N+11
      toggle(1'b1, 8'h41);
      step();
      run(10);
      check_eq("busy_n10", 32'(busy), 1);
      step();
      check_eq("busy_n11", 32'(busy), 0);
      run(3);

      // Clear command: 26 busy cycles
      toggle(1'b0, 8'h01);
      busy_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (busy) busy_cnt++;
      end
      check_eq("clear_busy_len", busy_cnt, 26);

      // Three toggles one cycle apart
      en_rises = 0;
      toggle(1'b1, 8'h11); step();
      toggle(1'b1, 8'h22); step();
      toggle(1'b1, 8'h33); step();
      run(40);
      check_eq("three_pulses", en_rises, 2);
      check_eq("three_ovr", 32'(overrun), 1);

      // ON bit without a request
      en_rises = 0;
      word[31] = 1'b1;
      step();
      check_eq("on_set", 32'(lcd_on), 1);
      run(5);
      check_eq("on_no_pulse", en_rises, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         word[30:11] = 20'($urandom);
         word[8] = 1'($urandom);
         if ($urandom_range(0, 15) == 0) word[31] = ~word[31];
         if ($urandom_range(0, 9) == 0) begin
            r = $urandom_range(0, 3);
            d = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom);
            toggle(1'($urandom), d);
         end
         step();
      end
      run(60);

      // Asynchronous reset during PULSE
      toggle(1'b1, 8'h5A);
      run(3);
      check_eq("pulse_before_rst", 32'(lcd_en), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_en", 32'(lcd_en), 0);
      check_eq("arst_busy", 32'(busy), 0);
      check_eq("arst_ovr", 32'(overrun), 0);
      check_eq("arst_data", 32'(lcd_data), 0);
      check_eq("arst_on", 32'(lcd_on), 0);
      repeat (2) @(negedge clk);
      word[10] = 1'b0;
      model_clear();
      rst_n = 1'b1;
      en_rises = 0;
      toggle(1'b1, 8'h77);
      run(20);
      check_eq("post_rst_pulse", en_rises, 1);

      // REQ held constant after one toggle
      en_rises = 0;
      toggle(1'b0, 8'h38);
      run(100);
      check_eq("hold_one_pulse", en_rises, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Bus-timing sequencer between the memory-mapped LCD output register and the HD44780-style character-LCD pins. Firmware writes one LCD command or data byte per register write, and this block turns it into a correctly timed RS/DATA setup, EN pulse, hold and execution wait. Firmware no longer has to bit-bang EN with software delays. It also provides a one-deep pending slot, a busy flag and an overrun flag.

## Interface
Parameters:
- T_SETUP, 3: cycles RS/DATA are stable before EN rises (≥40 ns at 50 MHz).
- T_PW, 12: cycles EN is high (≥230 ns).
- T_HOLD, 2: cycles RS/DATA are held after EN falls.
- T_EXEC, 2500: execution wait in cycles for normal commands and data (50 µs).
- T_LONG, 82000: execution wait in cycles for clear/home (1.64 ms).

Ports:
- i_clk, in, 1: the single clock.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_lcd_word, in, 32: LCD register contents. [31] ON, [10] REQ toggle, [9] RS, [8] RW (ignored), [7:0] DATA.
- o_lcd_on, out, 1: LCD power/backlight enable.
- o_lcd_en, out, 1: LCD EN strobe.
- o_lcd_rs, out, 1: register select.
- o_lcd_rw, out, 1: read/write select. Constant 0; write-only.
- o_lcd_data, out, 8: LCD data bus.
- o_busy, out, 1: high while a transaction is in progress or pending.
- o_overrun, out, 1: sticky; set when a request is dropped.

## Operation
- Reset values of all outputs are 0. Internal state after reset: state IDLE, req_last=0, pending empty, counter 0.
- o_lcd_on: registered copy of i_lcd_word[31]. 1-cycle latency, independent of the FSM.
- Request detect: a new request is a cycle where i_lcd_word[10] != req_last.
  - On that cycle, req_last <= i_lcd_word[10].
  - {RS, DATA} are captured from the same cycle.
  - Each toggle is exactly one request.
- Long command: RS=0 and DATA ∈ {8'h01, 8'h02}. The wait is T_LONG; otherwise it is T_EXEC.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE: on a request, load the bus registers, counter <= T_SETUP-1, go to SETUP.
  - SETUP: counter reaches 0 → EN <= 1, counter <= T_PW-1, go to PULSE.
  - PULSE: counter reaches 0 → EN <= 0, counter <= T_HOLD-1, go to HOLD.
  - HOLD: counter reaches 0 → counter <= wait-1, go to WAIT.
  - WAIT: counter reaches 0 → if pending is valid, load it, clear pending and go to SETUP (no IDLE cycle); else go to IDLE.
- Bus stability: o_lcd_rs and o_lcd_data change only on the IDLE→SETUP or WAIT→SETUP transition. They hold through SETUP, PULSE, HOLD and WAIT.
- Pending slot:
  - A request while not IDLE goes to the pending slot if it is empty.
  - If the slot is full, the request is dropped and o_overrun <= 1.
  - The pending slot is never overwritten.
- o_busy = (state != IDLE) | pending_valid, registered alongside the state.
- o_overrun clears only on reset.
- Counter width is $clog2(max(T_LONG, T_EXEC, T_PW, T_SETUP, T_HOLD)+1). All parameters must be ≥1; a count of 1 means a phase lasts one cycle.

## Timing
- Request sampled at edge N:
  - Edge N: state becomes SETUP; o_busy=1; RS/DATA are valid.
  - Edge N+T_SETUP: o_lcd_en rises.
  - Edge N+T_SETUP+T_PW: o_lcd_en falls.
  - Edge N+T_SETUP+T_PW+T_HOLD: state enters WAIT.
  - Edge N+T_SETUP+T_PW+T_HOLD+wait: state returns to IDLE; o_busy falls at this edge if nothing is pending.
- Back-to-back request in WAIT's final cycle: it is captured into pending, not lost. The next SETUP starts at the following edge.
- Request in the same cycle as WAIT→IDLE with pending empty: it goes to pending. The FSM goes IDLE for one cycle, then SETUP.
- Asynchronous reset mid-transaction: o_lcd_en drops to 0 immediately, with no clock needed. The transaction is abandoned, not resumed.

## Test plan
- Single data write: T_SETUP=2, T_PW=3, T_HOLD=1, T_EXEC=5, T_LONG=20. Toggle REQ with RS=1, DATA=8'h41.
  - Required: SETUP starts at edge N. EN is high during edges N+2..N+4, low from N+5. o_busy falls at edge N+11.
  - Required: RS=1 and DATA=8'h41 are stable throughout.
- Clear command (RS=0, DATA=8'h01) → WAIT lasts 20 cycles; o_busy is high for 26 cycles total.
- Three toggles 1 cycle apart during the first transaction:
  - First request executes; second is pending and executes immediately after WAIT.
  - Third is dropped: o_overrun=1 and stays 1.
  - Bus sequence shows exactly two EN pulses.
- ON bit: write bit31=1 with no REQ change → o_lcd_on=1 after 1 cycle; EN never pulses.
- Assert i_rst_n=0 while in PULSE → EN, busy, overrun and data all go to 0 immediately. After release, a new toggle (relative to req_last=0) starts cleanly.
- Hold REQ constant for 100 cycles after one toggle → exactly one EN pulse; o_lcd_rw is 0 throughout.
